// File: rtl/gal_reg_bank.sv
// gal_reg_bank
//   Bank of WIDTH registered macrocells with tri-state outputs. Shared clock
//   enable; mode selects hold, parallel load, serial shift or binary up-count.
//   Exposes a serial-out tap and a terminal-count flag so banks can be chained.
// Ports
//   clk   in   1      clock, all state changes on posedge
//   rst   in   1      synchronous active-high reset, loads RESET_VAL
//   ce    in   1      clock enable, 0 = hold regardless of mode
//   mode  in   2      00 HOLD, 01 LOAD, 10 SHIFT, 11 COUNT
//   d     in   WIDTH  parallel load data
//   sin   in   1      serial input into r[0]
//   oe    in   1      output enable, 0 = q all high-Z
//   q     out  WIDTH  q[i] = oe ? r[i] ^ INVERT[i] : 'z
//   sout  out  1      r[WIDTH-1], ungated
//   tc    out  1      high in the cycle whose edge wraps the counter
module gal_reg_bank #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = 4'b1001,
   parameter logic [WIDTH-1:0] INVERT    = 4'b0101
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic             oe,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             tc
);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_LOAD  = 2'b01,
      MODE_SHIFT = 2'b10,
      MODE_COUNT = 2'b11
   } mode_e;

   logic [WIDTH-1:0] r_q, r_d;
   mode_e            mode_s;

   assign mode_s = mode_e'(mode);

   always_comb begin
      r_d = r_q;
      if (ce) begin
         unique case (mode_s)
            MODE_HOLD:  r_d = r_q;
            MODE_LOAD:  r_d = d;
            // Truncating {r, sin} drops the old MSB; also covers WIDTH=1 (r <= sin).
            MODE_SHIFT: r_d = WIDTH'({r_q, sin});
            MODE_COUNT: r_d = r_q + WIDTH'(1);
            default:    r_d = r_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_q <= RESET_VAL;
      else     r_q <= r_d;
   end

   // Per-pin macrocell output buffer; polarity chosen per bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign q[i] = oe ? (r_q[i] ^ INVERT[i]) : 1'bz;
   end

   assign sout = r_q[WIDTH-1];
   // Qualified by rst so a reset edge is never reported as a wrap.
   assign tc   = ~rst & ce & (mode_s == MODE_COUNT) & (&r_q);

endmodule
